// File: rtl/nxsign_lanes.sv
// Per-lane sign sequencer: loads operand signs, applies a sign function ncyc times, flags done.
// Latency: 1 cycle to load, then ncyc RUN cycles; done is high for one unheld cycle afterwards.
// Backpressure: fpuhold freezes everything; start is ignored in RUN. NXSIGN_STICKY_EN adds sgn_flip.
module nxsign_lanes #(
    parameter int LANES = 2,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             fpuhold,
    input  logic             start,
    input  logic [LANES-1:0] asignin,
    input  logic [LANES-1:0] bsignin,
    input  logic [CNT_W-1:0] ncyc,
    input  logic [2:0]       asignfunc,
    input  logic [LANES-1:0] expsame,
    input  logic [LANES-1:0] altb,
    input  logic [LANES-1:0] ae_small,
    input  logic [LANES-1:0] morethree_taken,
    output logic [LANES-1:0] asign,
    output logic [LANES-1:0] bsign,
    output logic [LANES-1:0] eadd,
    output logic [LANES-1:0] absign,
`ifdef NXSIGN_STICKY_EN
    output logic [LANES-1:0] sgn_flip,
`endif
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LANES-1:0] asign_q, asign_d;
    logic [LANES-1:0] bsign_q, bsign_d;
    logic [LANES-1:0] eadd_q, eadd_d;
    logic [LANES-1:0] absign_q, absign_d;
    logic [LANES-1:0] nxa, nxb;
    logic             load, step;

    // Sequencer state: IDLE -> RUN (ncyc steps) -> DONE (one cycle) -> IDLE
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: load on accepted start, count down in RUN; nothing moves under fpuhold
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        if (!fpuhold) begin
            case (state_q)
                ST_IDLE: load = start;
                ST_RUN: begin
                    step  = 1'b1;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
                end
                ST_DONE: begin
                    load = start;
                    if (!start) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
            if (load) begin
                cnt_d   = ncyc;
                state_d = (ncyc != '0) ? ST_RUN : ST_DONE;
            end
        end
    end

    // Status outputs decode directly from the state register, so they are glitch-free
    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

    // Per-lane sign function; swap is suppressed when the quotient already took >3
    always_comb begin
        nxa = asign_q;
        nxb = bsign_q;
        for (int i = 0; i < LANES; i++) begin
            logic a, b, a_small, swap;
            a       = asign_q[i];
            b       = bsign_q[i];
            a_small = expsame[i] ? altb[i] : ae_small[i];
            swap    = a_small & ~morethree_taken[i];
            case (asignfunc)
                3'd0:    nxa[i] = a;
                3'd1:    nxa[i] = ~a;
                3'd2:    nxa[i] = a ^ b;
                3'd3:    nxa[i] = swap ? b : a;
                3'd4:    nxa[i] = a & b;
                3'd5:    nxa[i] = 1'b0;
                3'd6:    nxa[i] = b;
                default: nxa[i] = 1'b1;
            endcase
            nxb[i] = ((asignfunc == 3'd3) && swap) || (asignfunc == 3'd6) ? a : b;
        end
    end

    // Sign datapath: eadd/absign always derive from the values being written to asign/bsign
    always_comb begin
        asign_d  = asign_q;
        bsign_d  = bsign_q;
        eadd_d   = eadd_q;
        absign_d = absign_q;
        if (load) begin
            asign_d  = asignin;
            bsign_d  = bsignin;
            eadd_d   = ~(asignin ^ bsignin);
            absign_d = asignin & bsignin;
        end else if (step) begin
            asign_d  = nxa;
            bsign_d  = nxb;
            eadd_d   = ~(nxa ^ nxb);
            absign_d = nxa & nxb;
        end
    end

    // Sign registers
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            asign_q  <= '0;
            bsign_q  <= '0;
            eadd_q   <= '0;
            absign_q <= '0;
        end else begin
            asign_q  <= asign_d;
            bsign_q  <= bsign_d;
            eadd_q   <= eadd_d;
            absign_q <= absign_d;
        end
    end

    assign asign  = asign_q;
    assign bsign  = bsign_q;
    assign eadd   = eadd_q;
    assign absign = absign_q;

`ifdef NXSIGN_STICKY_EN
    logic [LANES-1:0] sgn_flip_q, sgn_flip_d;

    // Sticky per-lane record of any asign change during the current operation
    always_comb begin
        sgn_flip_d = sgn_flip_q;
        if (load)      sgn_flip_d = '0;
        else if (step) sgn_flip_d = sgn_flip_q | (nxa ^ asign_q);
    end

    // Sticky flag register
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) sgn_flip_q <= '0;
        else          sgn_flip_q <= sgn_flip_d;
    end

    assign sgn_flip = sgn_flip_q;
`endif

endmodule

// File: tb/tb_nxsign_lanes.sv
// Directed bench for nxsign_lanes (LANES=2): inputs driven and outputs sampled on the falling edge.
module tb_nxsign_lanes;

    logic       clk;
    logic       reset_l;
    logic       fpuhold;
    logic       start;
    logic [1:0] asignin, bsignin;
    logic [4:0] ncyc;
    logic [2:0] asignfunc;
    logic [1:0] expsame, altb, ae_small, morethree_taken;
    logic [1:0] asign, bsign, eadd, absign;
    logic       busy, done;
`ifdef NXSIGN_STICKY_EN
    logic [1:0] sgn_flip;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    nxsign_lanes #(.LANES(2), .CNT_W(5)) dut (
        .clk             (clk),
        .reset_l         (reset_l),
        .fpuhold         (fpuhold),
        .start           (start),
        .asignin         (asignin),
        .bsignin         (bsignin),
        .ncyc            (ncyc),
        .asignfunc       (asignfunc),
        .expsame         (expsame),
        .altb            (altb),
        .ae_small        (ae_small),
        .morethree_taken (morethree_taken),
        .asign           (asign),
        .bsign           (bsign),
        .eadd            (eadd),
        .absign          (absign),
`ifdef NXSIGN_STICKY_EN
        .sgn_flip        (sgn_flip),
`endif
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_start(input logic [1:0] a, input logic [1:0] b,
                               input logic [4:0] n, input logic [2:0] f);
        start     = 1'b1;
        asignin   = a;
        bsignin   = b;
        ncyc      = n;
        asignfunc = f;
    endtask

    task automatic test_reset();
        reset_l = 1'b1;
        #1 reset_l = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({asign, bsign, eadd, absign, busy, done} !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_state: got %b expected all zero", {asign, bsign, eadd, absign, busy, done});
        end
        reset_l = 1'b1;
    endtask

    // Start accepted on the very first edge after reset release, ncyc=0 goes straight to DONE
    task automatic test_zero_ncyc();
        drive_start(2'b01, 2'b10, 5'd0, 3'd0);
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if ({done, busy, asign, bsign, eadd, absign} !== {1'b1, 1'b0, 2'b01, 2'b10, 2'b00, 2'b00}) begin
            n_bad++;
            $display("FAIL zero_ncyc: got done=%b busy=%b a=%b b=%b e=%b s=%b expected 1 0 01 10 00 00",
                     done, busy, asign, bsign, eadd, absign);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, busy, asign, bsign} !== {1'b0, 1'b0, 2'b01, 2'b10}) begin
            n_bad++;
            $display("FAIL zero_ncyc_idle: got done=%b busy=%b a=%b b=%b expected 0 0 01 10",
                     done, busy, asign, bsign);
        end
    endtask

    task automatic test_toggle();
        logic [1:0] exp_a [3] = '{2'b11, 2'b00, 2'b11};
        logic [1:0] exp_e [3] = '{2'b00, 2'b11, 2'b00};
        drive_start(2'b00, 2'b00, 5'd3, 3'd1);
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if ({busy, done, asign} !== {1'b1, 1'b0, 2'b00}) begin
            n_bad++;
            $display("FAIL toggle_load: got busy=%b done=%b a=%b expected 1 0 00", busy, done, asign);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, done, asign, eadd} !== {(k < 2), (k == 2), exp_a[k], exp_e[k]}) begin
                n_bad++;
                $display("FAIL toggle_step%0d: got busy=%b done=%b a=%b e=%b expected %b %b %b %b",
                         k, busy, done, asign, eadd, (k < 2), (k == 2), exp_a[k], exp_e[k]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, done, asign} !== {1'b0, 1'b0, 2'b11}) begin
            n_bad++;
            $display("FAIL toggle_idle: got busy=%b done=%b a=%b expected 0 0 11", busy, done, asign);
        end
    endtask

    // Every function code, ncyc=1, lane0 a=1 b=1, lane1 a=0 b=1, no swap
    task automatic test_func_table();
        logic [1:0] ea [8] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b11, 2'b11};
        logic [1:0] eb [8] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b11};
        logic [1:0] ee [8] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b01, 2'b11};
        logic [1:0] es [8] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b01, 2'b11};
        expsame = 2'b00; altb = 2'b00; ae_small = 2'b00; morethree_taken = 2'b00;
        for (int f = 0; f < 8; f++) begin
            drive_start(2'b01, 2'b11, 5'd1, 3'(f));
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            n_cmp++;
            if ({done, asign, bsign, eadd, absign} !== {1'b1, ea[f], eb[f], ee[f], es[f]}) begin
                n_bad++;
                $display("FAIL func%0d: got done=%b a=%b b=%b e=%b s=%b expected 1 %b %b %b %b",
                         f, done, asign, bsign, eadd, absign, ea[f], eb[f], ee[f], es[f]);
            end
            @(negedge clk);
        end
    endtask

    // Function 3: lane0 swaps via expsame/altb; lane1 swap blocked, then allowed
    task automatic test_swap();
        expsame = 2'b01; altb = 2'b01; ae_small = 2'b10; morethree_taken = 2'b10;
        drive_start(2'b01, 2'b10, 5'd1, 3'd3);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({done, asign, bsign, eadd, absign} !== {1'b1, 2'b00, 2'b11, 2'b00, 2'b00}) begin
            n_bad++;
            $display("FAIL swap_lane0: got done=%b a=%b b=%b e=%b s=%b expected 1 00 11 00 00",
                     done, asign, bsign, eadd, absign);
        end
        @(negedge clk);
        morethree_taken = 2'b00;
        drive_start(2'b01, 2'b10, 5'd1, 3'd3);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({done, asign, bsign} !== {1'b1, 2'b10, 2'b01}) begin
            n_bad++;
            $display("FAIL swap_both: got done=%b a=%b b=%b expected 1 10 01", done, asign, bsign);
        end
        @(negedge clk);
        expsame = 2'b00; altb = 2'b00; ae_small = 2'b00;
    endtask

    // Hold for 4 cycles mid-RUN with ncyc=5, then hold done for 2 cycles
    task automatic test_hold();
        int c = 0;
        int busy_cnt = 0;
        drive_start(2'b00, 2'b00, 5'd5, 3'd1);
        @(negedge clk);
        start = 1'b0;
        while (!done && c < 40) begin
            if (busy) busy_cnt++;
            if (c >= 2 && c <= 5) begin
                n_cmp++;
                if ({busy, asign} !== {1'b1, 2'b11}) begin
                    n_bad++;
                    $display("FAIL hold_frozen_c%0d: got busy=%b a=%b expected 1 11", c, busy, asign);
                end
            end
            if (c == 1) fpuhold = 1'b1;
            if (c == 5) fpuhold = 1'b0;
            c++;
            @(negedge clk);
        end
        n_cmp++;
        if ({done, busy_cnt, asign} !== {1'b1, 32'd9, 2'b11}) begin
            n_bad++;
            $display("FAIL hold_busy_total: got done=%b busy_cycles=%0d a=%b expected 1 9 11",
                     done, busy_cnt, asign);
        end
        fpuhold = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({done, busy} !== 2'b10) begin
                n_bad++;
                $display("FAIL hold_done%0d: got done=%b busy=%b expected 1 0", k, done, busy);
            end
        end
        fpuhold = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({done, busy, asign} !== {1'b0, 1'b0, 2'b11}) begin
            n_bad++;
            $display("FAIL hold_release: got done=%b busy=%b a=%b expected 0 0 11", done, busy, asign);
        end
    endtask

    task automatic test_reset_mid_run();
        drive_start(2'b00, 2'b11, 5'd10, 3'd1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset_l = 1'b0;
        #1;
        n_cmp++;
        if ({asign, bsign, eadd, absign, busy, done} !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_async: got %b expected all zero", {asign, bsign, eadd, absign, busy, done});
        end
        @(negedge clk);
        reset_l = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({asign, bsign, busy, done} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_idle: got %b expected all zero", {asign, bsign, busy, done});
        end
    endtask

    // A start during RUN must neither reload the counter nor the signs
    task automatic test_start_in_run();
        drive_start(2'b10, 2'b01, 5'd3, 3'd0);
        @(negedge clk);
        drive_start(2'b01, 2'b10, 5'd0, 3'd0);
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if ({busy, done, asign, bsign} !== {1'b1, 1'b0, 2'b10, 2'b01}) begin
            n_bad++;
            $display("FAIL start_in_run: got busy=%b done=%b a=%b b=%b expected 1 0 10 01",
                     busy, done, asign, bsign);
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, done} !== 2'b10) begin
            n_bad++;
            $display("FAIL start_in_run_cnt: got busy=%b done=%b expected 1 0", busy, done);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, asign, bsign} !== {1'b1, 2'b10, 2'b01}) begin
            n_bad++;
            $display("FAIL start_in_run_done: got done=%b a=%b b=%b expected 1 10 01", done, asign, bsign);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        drive_start(2'b01, 2'b01, 5'd1, 3'd0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_first_done: got done=%b expected 1", done);
        end
        drive_start(2'b11, 2'b00, 5'd2, 3'd1);
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if ({busy, done, asign, bsign} !== {1'b1, 1'b0, 2'b11, 2'b00}) begin
            n_bad++;
            $display("FAIL b2b_load: got busy=%b done=%b a=%b b=%b expected 1 0 11 00",
                     busy, done, asign, bsign);
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({done, asign} !== {1'b1, 2'b11}) begin
            n_bad++;
            $display("FAIL b2b_second_done: got done=%b a=%b expected 1 11", done, asign);
        end
        drive_start(2'b10, 2'b10, 5'd0, 3'd0);
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if ({done, busy, asign, eadd, absign} !== {1'b1, 1'b0, 2'b10, 2'b11, 2'b10}) begin
            n_bad++;
            $display("FAIL b2b_zero: got done=%b busy=%b a=%b e=%b s=%b expected 1 0 10 11 10",
                     done, busy, asign, eadd, absign);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_end: got done=%b expected 0", done);
        end
    endtask

`ifdef NXSIGN_STICKY_EN
    task automatic test_sticky();
        drive_start(2'b00, 2'b00, 5'd2, 3'd1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({done, asign, sgn_flip} !== {1'b1, 2'b00, 2'b11}) begin
            n_bad++;
            $display("FAIL sticky_set: got done=%b a=%b flip=%b expected 1 00 11", done, asign, sgn_flip);
        end
        drive_start(2'b00, 2'b00, 5'd0, 3'd1);
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (sgn_flip !== 2'b00) begin
            n_bad++;
            $display("FAIL sticky_clear: got flip=%b expected 00", sgn_flip);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        fpuhold = 1'b0; start = 1'b0;
        asignin = '0; bsignin = '0; ncyc = '0; asignfunc = '0;
        expsame = '0; altb = '0; ae_small = '0; morethree_taken = '0;
        test_reset();
        test_zero_ncyc();
        test_toggle();
        test_func_table();
        test_swap();
        test_hold();
        test_reset_mid_run();
        test_start_in_run();
        test_back_to_back();
`ifdef NXSIGN_STICKY_EN
        test_sticky();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nxsign_lanes.md
NXSIGN_LANES -- requirements
Module: nxsign_lanes

Interface
REQ-001 SHALL have parameter LANES, default 2, number of independent sign lanes (1..8).
REQ-002 SHALL have parameter CNT_W, default 5, width of the iteration counter.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_l  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port fpuhold  input  1  freeze, all state held while 1.
REQ-006 SHALL have port start  input  1  load request, operands valid this cycle.
REQ-007 SHALL have ports asignin, bsignin  input  LANES each  per-lane operand signs loaded on accepted start.
REQ-008 SHALL have port ncyc  input  CNT_W  iteration count sampled on accepted start.
REQ-009 SHALL have port asignfunc  input  3  sign function applied on each RUN cycle, common to all lanes.
REQ-010 SHALL have ports expsame, altb, ae_small, morethree_taken  input  LANES each  per-lane compare and quotient status.
REQ-011 SHALL have ports asign, bsign, eadd, absign  output  LANES each  per-lane registered sign state.
REQ-012 SHALL have ports busy, done  output  1 each  sequencer status.

Function
REQ-013 SHALL derive per lane a_small = expsame ? altb : ae_small.
REQ-014 SHALL derive per lane swap = a_small & ~morethree_taken.
REQ-015 SHALL compute next asign per lane by asignfunc: 0 a; 1 ~a; 2 a^b; 3 swap?b:a; 4 a&b; 5 0; 6 b; 7 1.
REQ-016 SHALL compute next bsign per lane: func 3 with swap -> a; func 6 -> a; otherwise b.
REQ-017 SHALL register eadd = ~(nxa ^ nxb) and absign = nxa & nxb from the same next values written to asign/bsign.
REQ-018 SHALL run a three-state FSM: IDLE, RUN, DONE.
REQ-019 SHALL accept start only in IDLE or DONE with fpuhold=0: load asign/bsign from asignin/bsignin and load cnt from ncyc.
REQ-020 SHALL go from an accepted start to RUN when ncyc != 0, and to DONE when ncyc == 0.
REQ-021 SHALL, in RUN with fpuhold=0, apply REQ-015/016 once per cycle and decrement cnt.
REQ-022 SHALL leave RUN for DONE on the cycle in which cnt decrements from 1 to 0, so exactly ncyc function applications occur.
REQ-023 SHALL hold done=1 for exactly one unheld cycle in DONE, then return to IDLE unless start is accepted.
REQ-024 SHALL accept start in DONE as back-to-back, with done still 1 that cycle.
REQ-025 SHALL ignore start while in RUN, with no change to state or signs.
REQ-026 SHALL keep busy=1 exactly in RUN.
REQ-027 SHALL, when fpuhold=1, freeze FSM, cnt, and all outputs, including a done=1 held beyond one cycle.
REQ-028 SHALL, in IDLE and DONE without start, hold asign/bsign/eadd/absign.
REQ-029 SHALL process lanes independently; LANES=1 is legal.

Reset
REQ-030 SHALL, on reset_l=0 at any time including mid-RUN, asynchronously clear the FSM to IDLE, cnt to 0, and asign, bsign, eadd, absign, busy, done to 0.
REQ-031 SHALL accept start on the first clock edge after reset_l deasserts.

Configuration
REQ-032 SHALL provide macro NXSIGN_STICKY_EN.
REQ-033 SHALL, with NXSIGN_STICKY_EN defined, add output sgn_flip (LANES wide), set per lane when asign changes value during RUN, cleared on accepted start and on reset, and frozen by fpuhold.
REQ-034 SHALL, without NXSIGN_STICKY_EN, have no sgn_flip port and no related logic.

Verification
REQ-035 SHALL cover: LANES=2, start with asignin=2'b01, bsignin=2'b10, ncyc=0 -> done=1 the next cycle, asign=01, bsign=10, eadd=00, absign=00.
REQ-036 SHALL cover: ncyc=3, asignfunc=1, asignin=2'b00 -> busy for 3 cycles, asign toggles 11,00,11, then done=1 with asign=11.
REQ-037 SHALL cover: ncyc=1, func=3, lane0 expsame=1, altb=1, morethree_taken=0, a=1, b=0 -> lane0 asign=0, bsign=1.
REQ-038 SHALL cover: fpuhold=1 for 4 cycles mid-RUN with ncyc=5 -> cnt and signs frozen; total busy cycles = 9.
REQ-039 SHALL cover: reset_l=0 for 1 cycle mid-RUN -> all outputs 0 immediately and state IDLE; start during RUN and back-to-back start in DONE -> behaviour per REQ-025 and REQ-024.
REQ-040 SHALL cover, with NXSIGN_STICKY_EN: func=1, ncyc=2 -> sgn_flip=11 at done; a following start clears it to 00.
